// File: rtl/instructions_pkg.sv
// rtl/instructions_pkg.sv - shared widths and enums for the memory port arbiter
package instructions_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_IF = 2'd1,
        ST_WAIT_LS = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts cycles spent waiting for a memory response
module mem_wait_timer #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic active,
    output logic expired
);

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYC - 1);

    logic [7:0] cnt;

    // cnt holds the number of wait cycles already completed, so the
    // TIMEOUT_CYC-th wait cycle is the one seen with cnt == TIMEOUT_CYC-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (clear) begin
            cnt <= 8'd0;
        end else if (active) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expired = active && (cnt == LAST_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store
module mem_port_arbiter #(
    parameter int XLEN        = instructions_pkg::XLEN,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [3:0]      ls_be,
    input  logic [XLEN-1:0] ls_addr,
    input  logic [XLEN-1:0] ls_wdata,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [XLEN-1:0] ls_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            err
);

    import instructions_pkg::*;

    arb_state_t state, state_nxt;
    owner_t     last_owner;
    logic       ls_store_q;
    logic       sel_ls, any_req, grant, in_wait, expired, resp_done, timeout_abort;

    // on a tie the requester that did not own the previous transaction wins
    assign sel_ls        = ls_req && (!if_req || last_owner == OWN_IF);
    assign any_req       = (if_req || ls_req) && (state == ST_IDLE) && !rst;
    assign grant         = any_req && mem_gnt;
    assign in_wait       = (state == ST_WAIT_IF) || (state == ST_WAIT_LS);
    assign resp_done     = in_wait && (mem_rvalid || expired);
    assign timeout_abort = in_wait && expired && !mem_rvalid;

    mem_wait_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (grant),
        .active (in_wait),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_owner <= OWN_LS;
            ls_store_q <= 1'b0;
            err        <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                last_owner <= sel_ls ? OWN_LS : OWN_IF;
                ls_store_q <= sel_ls && ls_we;
            end
            if (timeout_abort) begin
                err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        mem_req   = any_req;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_gnt    = grant && !sel_ls;
        ls_gnt    = grant && sel_ls;
        if_rvalid = (state == ST_WAIT_IF) && resp_done;
        ls_rvalid = (state == ST_WAIT_LS) && resp_done;
        if_rdata  = '0;
        ls_rdata  = '0;

        if (any_req) begin
            if (sel_ls) begin
                mem_we    = ls_we;
                mem_be    = ls_be;
                mem_addr  = ls_addr;
                mem_wdata = ls_we ? ls_wdata : '0;
            end else begin
                mem_be    = 4'hF;
                mem_addr  = if_addr;
            end
        end

        // a timeout abort returns zero data; store acks never carry data
        if ((state == ST_WAIT_IF) && mem_rvalid) begin
            if_rdata = mem_rdata;
        end
        if ((state == ST_WAIT_LS) && mem_rvalid && !ls_store_q) begin
            ls_rdata = mem_rdata;
        end

        case (state)
            ST_IDLE:    if (grant) state_nxt = sel_ls ? ST_WAIT_LS : ST_WAIT_IF;
            ST_WAIT_IF,
            ST_WAIT_LS: if (resp_done) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int XLEN = 32;
    localparam int TO   = 8;
    localparam int NCYC = 4000;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_gnt, if_rvalid;
    logic [XLEN-1:0] if_rdata;
    logic            ls_req, ls_we;
    logic [3:0]      ls_be;
    logic [XLEN-1:0] ls_addr, ls_wdata;
    logic            ls_gnt, ls_rvalid;
    logic [XLEN-1:0] ls_rdata;
    logic            mem_req, mem_we;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_addr, mem_wdata;
    logic            mem_gnt, mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            err;

    mem_port_arbiter #(.XLEN(XLEN), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
        .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_wdata;
    } req_exp_t;

    typedef struct {
        int   cyc;
        logic ls;
    } gnt_exp_t;

    typedef struct {
        int          cyc;
        logic        ls;
        logic [31:0] data;
    } rsp_exp_t;

    req_exp_t req_q[$];
    gnt_exp_t gnt_q[$];
    rsp_exp_t rsp_q[$];

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    logic err_exp = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s cycle %0d: got output with no expectation queued", name, cyc);
    endtask

    // monitor: pops expectations whenever the DUT presents a request, grant or response
    always @(negedge clk) begin
        while (req_q.size() > 0 && req_q[0].cyc < cyc) begin
            check("mem_req_missed", 64'(req_q[0].cyc), 64'(cyc));
            void'(req_q.pop_front());
        end
        while (gnt_q.size() > 0 && gnt_q[0].cyc < cyc) begin
            check("gnt_missed", 64'(gnt_q[0].cyc), 64'(cyc));
            void'(gnt_q.pop_front());
        end
        while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
            check("rvalid_missed", 64'(rsp_q[0].cyc), 64'(cyc));
            void'(rsp_q.pop_front());
        end

        if (mem_req) begin
            if (req_q.size() == 0 || req_q[0].cyc != cyc) begin
                flag("mem_req_unexpected");
            end else begin
                req_exp_t e;
                e = req_q.pop_front();
                check("mem_we", 64'(mem_we), 64'(e.we));
                check("mem_be", 64'(mem_be), 64'(e.be));
                check("mem_addr", 64'(mem_addr), 64'(e.addr));
                if (e.chk_wdata) check("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
            end
        end

        if (if_gnt || ls_gnt) begin
            if (gnt_q.size() == 0 || gnt_q[0].cyc != cyc) begin
                flag("gnt_unexpected");
            end else begin
                gnt_exp_t g;
                g = gnt_q.pop_front();
                check("gnt_owner", 64'({if_gnt, ls_gnt}), g.ls ? 64'h1 : 64'h2);
            end
        end

        if (if_rvalid || ls_rvalid) begin
            if (rsp_q.size() == 0 || rsp_q[0].cyc != cyc) begin
                flag("rvalid_unexpected");
            end else begin
                rsp_exp_t r;
                r = rsp_q.pop_front();
                check("rvalid_owner", 64'({if_rvalid, ls_rvalid}), r.ls ? 64'h1 : 64'h2);
                check("rdata", 64'(r.ls ? ls_rdata : if_rdata), 64'(r.data));
            end
        end

        if (!if_rvalid) check("if_rdata_idle", 64'(if_rdata), 64'h0);
        if (!ls_rvalid) check("ls_rdata_idle", 64'(ls_rdata), 64'h0);
        check("err", 64'(err), 64'(err_exp));
    end

    // stimulus and transaction-level reference model
    initial begin
        logic        if_pend, ls_pend, win_ls, busy, owner_ls, owner_store, prefer_ls;
        logic        err_pend, do_rst;
        logic [31:0] if_a, ls_a, ls_d;
        logic        ls_w;
        logic [3:0]  ls_b;
        int          lat, waited;

        if_pend = 0; ls_pend = 0; busy = 0; owner_ls = 0; owner_store = 0;
        prefer_ls = 0; err_pend = 0; lat = 0; waited = 0;
        if_a = 0; ls_a = 0; ls_d = 0; ls_w = 0; ls_b = 0;

        // requests and a response held during reset must all be ignored
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h100;
        ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'h3; ls_addr = 32'h2000; ls_wdata = 32'hAABBCCDD;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h00500093;
        repeat (3) @(posedge clk);

        for (int n = 0; n < NCYC; n++) begin
            @(posedge clk);
            #1;
            cyc++;
            err_exp  = err_exp | err_pend;
            err_pend = 1'b0;

            do_rst = ($urandom_range(0, 99) == 0);
            rst    = do_rst;

            if (!if_pend && $urandom_range(0, 3) != 0) begin
                if_pend = 1'b1;
                if_a    = $urandom & 32'hFFFF_FFFC;
            end
            if (!ls_pend && $urandom_range(0, 3) != 0) begin
                ls_pend = 1'b1;
                ls_w    = 1'($urandom_range(0, 1));
                ls_b    = 4'($urandom_range(1, 15));
                ls_a    = $urandom;
                ls_d    = $urandom;
            end
            if_req = if_pend; if_addr = if_a;
            ls_req = ls_pend; ls_we = ls_w; ls_be = ls_b; ls_addr = ls_a; ls_wdata = ls_d;

            mem_gnt    = ($urandom_range(0, 3) != 0);
            mem_rdata  = $urandom;
            mem_rvalid = 1'b0;

            if (do_rst) begin
                busy       = 1'b0;
                prefer_ls  = 1'b0;
                err_exp    = 1'b0;
                mem_rvalid = 1'($urandom_range(0, 1));
            end else if (busy) begin
                waited++;
                if (waited == lat) begin
                    mem_rvalid = 1'b1;
                    rsp_q.push_back('{cyc: cyc, ls: owner_ls, data: owner_store ? 32'h0 : mem_rdata});
                    busy = 1'b0;
                end else if (waited == TO) begin
                    rsp_q.push_back('{cyc: cyc, ls: owner_ls, data: 32'h0});
                    err_pend = 1'b1;
                    busy     = 1'b0;
                end
            end else begin
                mem_rvalid = ($urandom_range(0, 7) == 0);
                if (if_pend || ls_pend) begin
                    win_ls = ls_pend && (!if_pend || prefer_ls);
                    if (win_ls)
                        req_q.push_back('{cyc: cyc, we: ls_w, be: ls_b, addr: ls_a, wdata: ls_d, chk_wdata: ls_w});
                    else
                        req_q.push_back('{cyc: cyc, we: 1'b0, be: 4'hF, addr: if_a, wdata: 32'h0, chk_wdata: 1'b0});
                    if (mem_gnt) begin
                        gnt_q.push_back('{cyc: cyc, ls: win_ls});
                        busy        = 1'b1;
                        owner_ls    = win_ls;
                        owner_store = win_ls && ls_w;
                        waited      = 0;
                        // latencies above TO never arrive and force a timeout
                        lat         = $urandom_range(1, 10);
                        prefer_ls   = !win_ls;
                        if (win_ls) ls_pend = 1'b0;
                        else        if_pend = 1'b0;
                    end
                end
            end
        end

        @(negedge clk);
        #1;
        check("req_q_left", 64'(req_q.size()), 64'h0);
        check("gnt_q_left", 64'(gnt_q.size()), 64'h0);
        check("rsp_q_left", 64'(rsp_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
